// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the parametrised register file.
//   - state_e        : clear-sequencer state (IDLE / SWEEP)
//   - DEFAULT_WIDTH  : default entry width (legacy 8x8 register file)
//   - DEFAULT_DEPTH  : default entry count
// -----------------------------------------------------------------------------
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

endpackage : reg_file_pkg

// File: rtl/reg_file_clear_seq.sv
// -----------------------------------------------------------------------------
// reg_file_clear_seq
// Clear-sweep sequencer for reg_file_param. When the sweep starts, it walks
// a pointer from 0 up to DEPTH-1, one entry per clock. While the sweep runs,
// any user write is rejected, and that rejection is flagged on drop.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high
//   clear     in   request a sweep (only honoured in IDLE)
//   write     in   user write enable (used only to detect dropped writes)
//   busy      out  sweep in progress (state == SWEEP)
//   sweep_we  out  zero storage entry [ptr] at the next edge
//   ptr       out  current sweep position
//   drop      out  registered one-cycle pulse: a write was rejected
// -----------------------------------------------------------------------------
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          write,
  output logic          busy,
  output logic          sweep_we,
  output logic [AW-1:0] ptr,
  output logic          drop
);

  localparam logic [AW-1:0] PTR_ZERO = AW'(32'd0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q,   ptr_d;
  logic          drop_q,  drop_d;

  // Next-state logic for the sequencer: start, advance and end of the sweep.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          ptr_d   = PTR_ZERO;
        end else begin
          state_d = IDLE;
          ptr_d   = ptr_q;
        end
      end
      SWEEP: begin
        // A write that arrives during the sweep is lost. Flag it. CLEAR is
        // ignored here, so a second request never extends the sweep.
        drop_d = write;
        if (ptr_q == PTR_LAST) begin
          // This edge zeroes the last entry. Return to IDLE with the pointer
          // parked at 0 instead of letting it wrap.
          state_d = IDLE;
          ptr_d   = PTR_ZERO;
        end else begin
          state_d = SWEEP;
          ptr_d   = ptr_q + PTR_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = PTR_ZERO;
      end
    endcase
  end

  // Sequencer state registers. Reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_ZERO;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  assign busy     = (state_q == SWEEP);
  assign sweep_we = (state_q == SWEEP);
  assign ptr      = ptr_q;
  assign drop     = drop_q;

endmodule : reg_file_clear_seq

// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
// WIDTH x DEPTH register file. It has one synchronous write port, two
// combinational read ports and a sequential clear sweep. With WIDTH=8 and
// DEPTH=8 it is a drop-in replacement for the legacy CPU register file.
//
// Optional feature: define REGFILE_BYPASS_EN to forward IN straight to a read
// port in the cycle that writes the same address. Without it, new data
// appears only after the write edge.
//
// Ports:
//   CLK          in   clock, all state changes on the rising edge
//   RESET        in   synchronous, active-high; clears all entries
//   IN           in   write data
//   INADDRESS    in   write address
//   WRITE        in   write enable (ignored while BUSY)
//   OUT1ADDRESS  in   read port 1 address
//   OUT2ADDRESS  in   read port 2 address
//   OUT1, OUT2   out  read data (combinational)
//   CLEAR        in   start a clear sweep (DEPTH cycles)
//   BUSY         out  clear sweep in progress
//   DROP         out  registered one-cycle pulse: a write was rejected
// -----------------------------------------------------------------------------
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    INADDRESS,
  input  logic             WRITE,
  input  logic [AW-1:0]    OUT1ADDRESS,
  input  logic [AW-1:0]    OUT2ADDRESS,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  input  logic             CLEAR,
  output logic             BUSY,
  output logic             DROP
);

  logic             busy_s;
  logic             sweep_we_s;
  logic [AW-1:0]    sweep_ptr_s;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  reg_file_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk      (CLK),
    .reset    (RESET),
    .clear    (CLEAR),
    .write    (WRITE),
    .busy     (busy_s),
    .sweep_we (sweep_we_s),
    .ptr      (sweep_ptr_s),
    .drop     (DROP)
  );

  assign BUSY = busy_s;

  // Next contents of each entry. The sweep wins over a user write. User
  // writes are blocked for the whole sweep, not only at the swept entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (sweep_we_s && (sweep_ptr_s == AW'(i))) begin
        mem_d[i] = {WIDTH{1'b0}};
      end else if (WRITE && !busy_s && (INADDRESS == AW'(i))) begin
        mem_d[i] = IN;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Storage array. RESET zeroes every entry and overrides any write or sweep.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_en_s;

  // Forward only a write that will actually commit at the next edge.
  assign fwd_en_s = WRITE && !busy_s && !RESET;

  // Read ports with same-cycle forwarding. Each port forwards on its own.
  always_comb begin
    if (fwd_en_s && (INADDRESS == OUT1ADDRESS)) begin
      OUT1 = IN;
    end else begin
      OUT1 = mem_q[OUT1ADDRESS];
    end
    if (fwd_en_s && (INADDRESS == OUT2ADDRESS)) begin
      OUT2 = IN;
    end else begin
      OUT2 = mem_q[OUT2ADDRESS];
    end
  end
`else
  // Read ports return stored contents only (legacy timing).
  always_comb begin
    OUT1 = mem_q[OUT1ADDRESS];
    OUT2 = mem_q[OUT2ADDRESS];
  end
`endif

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// -----------------------------------------------------------------------------
// tb_reg_file_param
// Bench for reg_file_param. Instance A is the legacy 8x8 configuration.
// Instance B is WIDTH=16, DEPTH=32. A behavioural model tracks each register
// file as an array plus a "sweep cycles remaining" count. A compare process
// checks every DUT output against the model on each falling edge. Directed
// sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_reg_file_param;

  logic        CLK = 1'b0;
  logic        rst [2];
  logic        wr  [2];
  logic        clr [2];
  logic [15:0] din [2];
  logic [4:0]  wa  [2];
  logic [4:0]  ra1 [2];
  logic [4:0]  ra2 [2];

  logic [7:0]  o1a, o2a;
  logic [15:0] o1b, o2b;
  logic        busy_a, drop_a, busy_b, drop_b;

  int checks = 0;
  int errors = 0;

  // Model state: per instance, entry contents, remaining sweep cycles, drop flag.
  int          dep [2] = '{8, 32};
  logic [15:0] m_mem  [2][32];
  int          m_left [2] = '{0, 0};
  logic        m_drop [2] = '{1'b0, 1'b0};

  always #5 CLK = ~CLK;

  reg_file_param #(.WIDTH(8), .DEPTH(8)) dut_a (
    .CLK(CLK), .RESET(rst[0]), .IN(din[0][7:0]), .INADDRESS(wa[0][2:0]),
    .WRITE(wr[0]), .OUT1ADDRESS(ra1[0][2:0]), .OUT2ADDRESS(ra2[0][2:0]),
    .OUT1(o1a), .OUT2(o2a), .CLEAR(clr[0]), .BUSY(busy_a), .DROP(drop_a)
  );

  reg_file_param #(.WIDTH(16), .DEPTH(32)) dut_b (
    .CLK(CLK), .RESET(rst[1]), .IN(din[1]), .INADDRESS(wa[1]),
    .WRITE(wr[1]), .OUT1ADDRESS(ra1[1]), .OUT2ADDRESS(ra2[1]),
    .OUT1(o1b), .OUT2(o2b), .CLEAR(clr[1]), .BUSY(busy_b), .DROP(drop_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update: reset, then an active sweep, then an idle write/clear.
  always @(posedge CLK) begin
    for (int n = 0; n < 2; n++) begin
      if (rst[n]) begin
        for (int k = 0; k < 32; k++) m_mem[n][k] <= 16'h0000;
        m_left[n] <= 0;
        m_drop[n] <= 1'b0;
      end else if (m_left[n] > 0) begin
        m_mem[n][dep[n] - m_left[n]] <= 16'h0000;
        m_left[n] <= m_left[n] - 1;
        m_drop[n] <= wr[n];
      end else begin
        m_drop[n] <= 1'b0;
        if (wr[n]) m_mem[n][int'(wa[n]) % dep[n]] <= din[n];
        if (clr[n]) m_left[n] <= dep[n];
      end
    end
  end

  function automatic logic [15:0] exp_rd(input int n, input logic [4:0] a);
    logic [15:0] v;
    int idx;
    idx = int'(a) % dep[n];
    v = m_mem[n][idx];
`ifdef REGFILE_BYPASS_EN
    if (wr[n] && (m_left[n] == 0) && !rst[n] && ((int'(wa[n]) % dep[n]) == idx)) v = din[n];
`endif
    return (n == 0) ? (v & 16'h00FF) : v;
  endfunction

  // Compare process: every output of both instances on every falling edge.
  always @(negedge CLK) begin
    chk("a_out1", {24'h0, o1a}, {16'h0, exp_rd(0, ra1[0])});
    chk("a_out2", {24'h0, o2a}, {16'h0, exp_rd(0, ra2[0])});
    chk("a_busy", {31'h0, busy_a}, {31'h0, m_left[0] > 0});
    chk("a_drop", {31'h0, drop_a}, {31'h0, m_drop[0]});
    chk("b_out1", {16'h0, o1b}, {16'h0, exp_rd(1, ra1[1])});
    chk("b_out2", {16'h0, o2b}, {16'h0, exp_rd(1, ra2[1])});
    chk("b_busy", {31'h0, busy_b}, {31'h0, m_left[1] > 0});
    chk("b_drop", {31'h0, drop_b}, {31'h0, m_drop[1]});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_a(input logic [4:0] a, input logic [15:0] d);
    wr[0] = 1'b1; wa[0] = a; din[0] = d;
    tick();
    wr[0] = 1'b0;
  endtask

  // Count the cycles during which BUSY is still high, starting now (bounded).
  task automatic count_busy(input int inst, input int bound, output int cnt);
    cnt = 0;
    for (int c = 0; c < bound; c++) begin
      if (!((inst == 0) ? busy_a : busy_b)) break;
      cnt++;
      tick();
    end
  endtask

  initial begin
    int cnt;
    for (int n = 0; n < 2; n++) begin
      rst[n] = 1'b1; wr[n] = 1'b0; clr[n] = 1'b0;
      din[n] = 16'h0; wa[n] = 5'd0; ra1[n] = 5'd0; ra2[n] = 5'd0;
    end
    tick(); tick();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Reset: fill with 0xAA, reset for one edge, every address reads 0.
    for (int i = 0; i < 8; i++) write_a(5'(i), 16'h00AA);
    ra1[0] = 5'd3; #1;
    chk("pre_reset_aa", {24'h0, o1a}, 32'h0000_00AA);
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    chk("reset_busy", {31'h0, busy_a}, 32'h0);
    chk("reset_drop", {31'h0, drop_a}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      ra1[0] = 5'(a); ra2[0] = 5'(7 - a); #1;
      chk("reset_out1", {24'h0, o1a}, 32'h0);
      chk("reset_out2", {24'h0, o2a}, 32'h0);
      tick();
    end

    // Write/read at address 3, both ports.
    ra1[0] = 5'd3; ra2[0] = 5'd3;
    wr[0] = 1'b1; wa[0] = 5'd3; din[0] = 16'h005C; #1;
`ifdef REGFILE_BYPASS_EN
    chk("wr_same_cycle1", {24'h0, o1a}, 32'h5C);
    chk("wr_same_cycle2", {24'h0, o2a}, 32'h5C);
`else
    chk("wr_same_cycle1", {24'h0, o1a}, 32'h0);
    chk("wr_same_cycle2", {24'h0, o2a}, 32'h0);
`endif
    tick(); wr[0] = 1'b0; #1;
    chk("wr_after_edge1", {24'h0, o1a}, 32'h5C);
    chk("wr_after_edge2", {24'h0, o2a}, 32'h5C);

    // Sweep: preload 0xFF, BUSY lasts 8 cycles, entries fall in order.
    for (int i = 0; i < 8; i++) write_a(5'(i), 16'h00FF);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    tick(); tick(); tick();
    ra1[0] = 5'd2; ra2[0] = 5'd3; #1;
    chk("sweep_e3_entry2", {24'h0, o1a}, 32'h0);
    chk("sweep_e3_entry3", {24'h0, o2a}, 32'hFF);
    count_busy(0, 40, cnt);
    chk("sweep_busy_len", cnt, 32'd5);
    for (int a = 0; a < 8; a++) begin
      ra1[0] = 5'(a); #1;
      chk("sweep_all_zero", {24'h0, o1a}, 32'h0);
    end

    // Dropped write during sweep cycle 2, plus a CLEAR mid-sweep.
    write_a(5'd7, 16'h0033);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    tick();
    wr[0] = 1'b1; wa[0] = 5'd7; din[0] = 16'h0011; clr[0] = 1'b1;
    tick();
    wr[0] = 1'b0; clr[0] = 1'b0;
    chk("drop_high", {31'h0, drop_a}, 32'h1);
    tick();
    chk("drop_low", {31'h0, drop_a}, 32'h0);
    count_busy(0, 40, cnt);
    chk("drop_busy_rest", cnt, 32'd5);
    ra1[0] = 5'd7; #1;
    chk("drop_entry7", {24'h0, o1a}, 32'h0);

    // Reset at sweep cycle 4, then a normal write.
    write_a(5'd6, 16'h0066);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    tick(); tick(); tick();
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    chk("rst_mid_busy", {31'h0, busy_a}, 32'h0);
    ra1[0] = 5'd6; ra2[0] = 5'd7; #1;
    chk("rst_mid_entry6", {24'h0, o1a}, 32'h0);
    chk("rst_mid_entry7", {24'h0, o2a}, 32'h0);
    write_a(5'd5, 16'h0042);
    ra1[0] = 5'd5; #1;
    chk("rst_mid_write5", {24'h0, o1a}, 32'h42);

    // CLEAR with WRITE in IDLE: the write lands and is swept later.
    wr[0] = 1'b1; wa[0] = 5'd4; din[0] = 16'h0077; clr[0] = 1'b1;
    tick(); wr[0] = 1'b0; clr[0] = 1'b0;
    ra1[0] = 5'd4; #1;
    chk("clr_wr_commit", {24'h0, o1a}, 32'h77);
    count_busy(0, 40, cnt);
    chk("clr_wr_busy", cnt, 32'd8);
    chk("clr_wr_zeroed", {24'h0, o1a}, 32'h0);

    // 16x32 instance: write top entry, then a 32-cycle sweep.
    wr[1] = 1'b1; wa[1] = 5'd31; din[1] = 16'hBEEF;
    tick(); wr[1] = 1'b0;
    ra1[1] = 5'd31; ra2[1] = 5'd31; #1;
    chk("b_beef1", {16'h0, o1b}, 32'hBEEF);
    chk("b_beef2", {16'h0, o2b}, 32'hBEEF);
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    count_busy(1, 80, cnt);
    chk("b_sweep_len", cnt, 32'd32);
    chk("b_swept31", {16'h0, o1b}, 32'h0);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_param
